// File: rtl/memory_access_arbiter.sv
// Arbiter sharing one unified memory between the CPU and a DMA/loader port.
// Optional CPU stall statistics are enabled by defining MEMARB_STALL_STATS_EN.
module memory_access_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  output logic                  dma_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [31:0]           stall_cycles
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic                  gnt_q;
  logic                  last_q;
  logic                  we_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] cpu_rdata_q;
  logic [DATA_WIDTH-1:0] dma_rdata_q;
  logic                  pick_dma;

  // Grant encoding: 1 = DMA, 0 = CPU; on a tie the side that went last loses.
  assign pick_dma = dma_req & (~cpu_req | ~last_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req || dma_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      cnt_q       <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req || dma_req) begin
            gnt_q   <= pick_dma;
            we_q    <= pick_dma ? dma_we : cpu_we;
            addr_q  <= pick_dma ? dma_addr : cpu_addr;
            wdata_q <= pick_dma ? dma_wdata : cpu_wdata;
            cnt_q   <= WS;
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (!we_q) begin
            if (gnt_q) dma_rdata_q <= mem_rdata;
            else       cpu_rdata_q <= mem_rdata;
          end
        end
        RESP:    last_q <= gnt_q;
        default: ;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    mem_re  = 1'b0;
    mem_we  = 1'b0;
    cpu_ack = 1'b0;
    dma_ack = 1'b0;
    case (state_q)
      ACCESS: begin
        mem_re = ~we_q;
        mem_we = we_q & (cnt_q == WS);
      end
      RESP: begin
        cpu_ack = ~gnt_q;
        dma_ack = gnt_q;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

`ifdef MEMARB_STALL_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               stall_q <= '0;
    else if (cpu_req && !cpu_ack) stall_q <= sat_inc(stall_q);
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
